// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU units: logic-op encoding and result flags.
package alu_pkg;

    typedef enum logic [2:0] {
        LOP_AND   = 3'd0,
        LOP_OR    = 3'd1,
        LOP_XOR   = 3'd2,
        LOP_NAND  = 3'd3,
        LOP_NOR   = 3'd4,
        LOP_XNOR  = 3'd5,
        LOP_NOTA  = 3'd6,
        LOP_PASSB = 3'd7
    } lop_e;

    typedef struct packed {
        logic zero;
        logic parity;
    } flags_t;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic function f(a, b, op) with zero/parity flags.
module logic_unit_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  lop_e             op,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    always_comb begin
        case (op)
            LOP_AND:   result = a & b;
            LOP_OR:    result = a | b;
            LOP_XOR:   result = a ^ b;
            LOP_NAND:  result = ~(a & b);
            LOP_NOR:   result = ~(a | b);
            LOP_XNOR:  result = ~(a ^ b);
            LOP_NOTA:  result = ~a;
            LOP_PASSB: result = b;
            default:   result = '0;
        endcase
    end

    always_comb begin
        flags.zero   = (result == '0);
        flags.parity = ^result;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Elastic pipelined logic unit with valid/ready handshake and a running accumulator.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [WIDTH-1:0] acc_value
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  data [STAGES];
    flags_t            flg  [STAGES];
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  res;
    flags_t            res_flags;
    logic              in_fire;

    always_comb begin
        op_b = in_b;
        if (in_acc_en) begin
            op_b = acc_clr ? '0 : acc;
        end
    end

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a      (in_a),
        .b      (op_b),
        .op     (lop_e'(in_op)),
        .result (res),
        .flags  (res_flags)
    );

    // adv[k] = !v[k] | adv[k+1], unrolled from the output end as a running OR
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            run = run | ~v[STAGES-1-k];
            adv[STAGES-1-k] = run;
        end
    end

    assign in_ready = ~v[0] | adv[0];
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data[k] <= '0;
                flg[k]  <= '0;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_fire;
                if (in_fire) begin
                    data[0] <= res;
                    flg[0]  <= res_flags;
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v[k]    <= v[k-1];
                    data[k] <= data[k-1];
                    flg[k]  <= flg[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (in_fire && in_acc_en) begin
            acc <= res;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    assign out_valid  = v[STAGES-1];
    assign out_result = data[STAGES-1];
    assign out_zero   = flg[STAGES-1].zero;
    assign out_parity = flg[STAGES-1].parity;
    assign acc_value  = acc;

endmodule
